spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

SPI slave front-end that turns SPI frames from an external host into single-cycle register-bus transactions (reg_cs/reg_wr/reg_addr/reg_din, read data on reg_dout), acting as the bus initiator for the register bank. SPI mode 0 (CPOL=0, CPHA=0), MSB first. All SPI inputs are oversampled in the clk domain; no logic is clocked by sclk.

## Interface
- DWIDTH, 16, register data width
- ALINES, 7, register address width
- clk  in  1  system clock; must be at least 8x sclk frequency
- rst  in  1  reset, asynchronous, active-high
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active-low, asynchronous
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- miso_oe  out  1  MISO output enable (high while frame active)
- reg_cs  out  1  register bus select, one-cycle pulse per access
- reg_wr  out  1  register bus write strobe, only with reg_cs
- reg_addr  out  ALINES  register address
- reg_din  out  DWIDTH  register write data
- reg_dout  in  DWIDTH  register read data, combinational from reg_cs/reg_addr
- frame_err  out  1  one-cycle pulse on malformed frame
- busy  out  1  high from frame start until cs_n deasserted

## Operation
- Frame = 1 command bit (1 = read, 0 = write) + ALINES address bits + DWIDTH data bits, MSB first; CLEN = 1+ALINES = 8, FLEN = CLEN+DWIDTH = 24 at defaults.
- sclk, cs_n, mosi each pass a 2-FF synchronizer (sclk/cs_n stages reset to 1/1, mosi to 0), plus a third stage for edge detection.
- mosi sampled on detected sclk rising edge; miso changes only on detected sclk falling edge.
- States: IDLE, CMD, RD_ACC, DATA, WR_ACC, DONE.
- IDLE: frame starts only on detected cs_n falling edge while armed; bit counter cleared; -> CMD. armed clears on reset, sets once synced cs_n is seen high.
- CMD: shift mosi into command register per rising edge; after bit CLEN, latch reg_addr; read -> RD_ACC, write -> DATA.
- RD_ACC: one cycle, reg_cs=1, reg_wr=0; reg_dout captured into tx shift register at the end of that cycle; -> DATA.
- DATA: write: shift mosi into rx register; read: on each falling edge after rising edge CLEN+1 through FLEN-1, shift tx register left. miso = tx MSB. After rising edge FLEN: write -> WR_ACC, read -> DONE.
- WR_ACC: one cycle, reg_cs=1, reg_wr=1, reg_din = received data; -> DONE.
- DONE: ignore further sclk edges (no second access, no error); wait for cs_n high -> IDLE.
- cs_n rising edge in CMD or DATA (bit count 1..FLEN-1): abort, no write issued, frame_err pulses one cycle, -> IDLE. cs_n high with zero bits: -> IDLE, no error.
- A read access already issued is not retracted on abort (reads have no side effect).
- miso = 0 outside DATA of a read frame; miso_oe = busy.
- reg_addr and reg_din hold their last values between accesses.

## Timing
- Reset values: miso 0, miso_oe 0, reg_cs 0, reg_wr 0, reg_addr 0, reg_din 0, frame_err 0, busy 0; state IDLE, armed 0.
- Synchronizer latency: 3 clk from pin edge to detection.
- reg_cs for read: asserted 1 clk after detection of rising edge CLEN; first data bit on miso no later than 3 clk after that, i.e. before falling edge CLEN completes at 8x oversampling.
- reg_cs/reg_wr for write: asserted 1 clk after detection of rising edge FLEN, exactly one cycle wide.
- Exactly one reg_cs pulse per complete frame; zero for aborted writes.
- Rst asserted mid-frame: all outputs return to reset values immediately; no access issued; after release, the in-flight frame is ignored until cs_n is seen high.
- Back-to-back frames with cs_n high for >= 4 clk are both accepted.

## Test plan
- Write frame 0x05 / 0xA5C3 (bits 0_0000101_1010010111000011) -> single one-cycle reg_cs & reg_wr, reg_addr=0x05, reg_din=0xA5C3; no frame_err.
- Read frame addr 0x03, reg_dout=0x1234 -> one reg_cs pulse with reg_wr=0, reg_addr=0x03; miso on rising edges 9..24 = 0001001000110100; miso=0 during bits 1..8.
- Write frame truncated after 20 bits -> no reg_wr, frame_err one pulse, busy drops, next valid frame works.
- 30-bit write frame -> exactly one write at bit 24, no frame_err, extra bits ignored.
- Two back-to-back frames (write 0x01/0xFFFF then read 0x01) with cs_n high 1 sclk period -> two accesses, read returns value driven on reg_dout.
- Rst pulsed at bit 12 of a write -> outputs reset, no access; cs_n kept low through bit 24 -> still no access; next frame after cs_n high is accepted.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that converts each host frame (cmd, address, data) into a
// single-cycle register-bus access. Every SPI pin is oversampled in the clk domain.
module spi_reg_bridge #(
    parameter int DWIDTH = 16,
    parameter int ALINES = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              reg_cs,
    output logic              reg_wr,
    output logic [ALINES-1:0] reg_addr,
    output logic [DWIDTH-1:0] reg_din,
    input  logic [DWIDTH-1:0] reg_dout,
    output logic              frame_err,
    output logic              busy
);

    localparam int CLEN = 1 + ALINES;
    localparam int FLEN = CLEN + DWIDTH;
    localparam int CW   = $clog2(FLEN + 1);

    typedef enum logic [2:0] {IDLE, CMD, RD_ACC, DATA, WR_ACC, DONE} state_t;

    state_t state, state_next;

    logic [2:0]        sclk_sync, cs_sync;
    logic [1:0]        mosi_sync;
    logic [1:0]        fill_cnt;
    logic              armed;
    logic [CW-1:0]     bit_cnt;
    logic [CLEN-2:0]   cmd_sr;
    logic [DWIDTH-2:0] rx_sr;
    logic [DWIDTH-1:0] tx_sr;
    logic              is_read;

    logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_bit;
    logic [CLEN-1:0]   cmd_next;
    logic [DWIDTH-1:0] rx_next;
    logic clr_cnt, inc_cnt, shift_cmd, latch_addr, load_tx, shift_tx, shift_rx, latch_din, abort;

    // Stage [1] is the synchronized level, stage [2] its delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 3'b111;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
            fill_cnt  <= 2'd0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            if (fill_cnt != 2'd3)
                fill_cnt <= fill_cnt + 2'd1;
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_high   = cs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign cmd_next  = {cmd_sr, mosi_bit};
    assign rx_next   = {rx_sr, mosi_bit};

    // The reset value of the synchronizer is not a real observation of cs_n, so
    // arming waits until the chain has been refilled from the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            armed <= 1'b0;
        else if (fill_cnt[1] && cs_high)
            armed <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        shift_cmd  = 1'b0;
        latch_addr = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        shift_rx   = 1'b0;
        latch_din  = 1'b0;
        abort      = 1'b0;
        reg_cs     = 1'b0;
        reg_wr     = 1'b0;
        miso       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (armed && cs_fall) begin
                    clr_cnt    = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (cs_high) begin
                    abort      = (bit_cnt != '0);
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    shift_cmd = 1'b1;
                    inc_cnt   = 1'b1;
                    if (bit_cnt == CW'(CLEN - 1)) begin
                        latch_addr = 1'b1;
                        state_next = cmd_next[CLEN-1] ? RD_ACC : DATA;
                    end
                end
            end
            RD_ACC: begin
                reg_cs     = 1'b1;
                load_tx    = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                miso = is_read & tx_sr[DWIDTH-1];
                if (cs_high) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    inc_cnt  = 1'b1;
                    shift_rx = ~is_read;
                    if (bit_cnt == CW'(FLEN - 1)) begin
                        latch_din  = ~is_read;
                        state_next = is_read ? DONE : WR_ACC;
                    end
                end else if (sclk_fall && is_read && bit_cnt >= CW'(CLEN + 1)) begin
                    shift_tx = 1'b1;
                end
            end
            WR_ACC: begin
                reg_cs     = 1'b1;
                reg_wr     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (cs_high)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign miso_oe = busy;

    // Frame datapath, steered entirely by the strobes decoded in the FSM above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            is_read   <= 1'b0;
            reg_addr  <= '0;
            reg_din   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (clr_cnt)
                bit_cnt <= '0;
            else if (inc_cnt)
                bit_cnt <= bit_cnt + CW'(1);
            if (shift_cmd)
                cmd_sr <= cmd_next[CLEN-2:0];
            if (latch_addr) begin
                reg_addr <= cmd_next[ALINES-1:0];
                is_read  <= cmd_next[CLEN-1];
            end
            if (load_tx)
                tx_sr <= reg_dout;
            else if (shift_tx)
                tx_sr <= {tx_sr[DWIDTH-2:0], 1'b0};
            if (shift_rx)
                rx_sr <= rx_next[DWIDTH-2:0];
            if (latch_din)
                reg_din <= rx_next;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: an SPI host drives frames while a
// frame-level model predicts bus accesses, error pulses and the MISO stream.
module tb_spi_reg_bridge;

    localparam int CLEN = 8;
    localparam int FLEN = 24;
    localparam int HALF = 6;
    localparam int GAP  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, reg_cs, reg_wr, frame_err, busy;
    logic [6:0]  reg_addr;
    logic [15:0] reg_din, reg_dout;

    logic        bank_init = 1'b1;
    logic [15:0] bank [128];
    logic [15:0] model_regs [128];

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          acc_count = 0;
    logic        prev_cs = 1'b0;
    logic [63:0] miso_cap;

    spi_reg_bridge #(.DWIDTH(16), .ALINES(7)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .reg_cs(reg_cs), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(input int i);
        return (i == 3) ? 16'h1234 : (16'(i) * 16'h0101) ^ 16'h5A00;
    endfunction

    // Register bank seen by the bridge; read data only valid while selected.
    assign reg_dout = reg_cs ? bank[reg_addr] : 16'h0000;

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 128; i++)
                bank[i] <= initVal(i);
        end else if (reg_cs && reg_wr) begin
            bank[reg_addr] <= reg_din;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Every bus access must match the head of the expected-access queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr)
                checkOutput("wr_needs_cs", reg_cs, 1);
            if (reg_cs) begin
                acc_t e;
                acc_count++;
                checkOutput("access_expected", 64'(exp_q.size() > 0), 1);
                checkOutput("cs_one_cycle", prev_cs, 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("acc_wr", reg_wr, e.wr);
                    checkOutput("acc_addr", reg_addr, e.addr);
                    if (e.wr)
                        checkOutput("acc_din", reg_din, e.data);
                end
            end
            if (frame_err)
                err_seen++;
        end
        prev_cs <= reg_cs;
    end

    // Frame-level model: bit i (1-based, first on the wire) is bits[nbits-i].
    task automatic modelFrame(input logic [63:0] bits, input int nbits, input int rst_at,
                              output logic [63:0] exp_miso, output int exp_err);
        logic        cmd;
        logic [6:0]  addr;
        logic [15:0] data;
        exp_miso = '0;
        exp_err  = 0;
        if (rst_at > 0)
            return;
        exp_err = (nbits >= 1 && nbits < FLEN) ? 1 : 0;
        if (nbits < CLEN)
            return;
        cmd  = bits[nbits-1];
        addr = '0;
        for (int i = 2; i <= CLEN; i++)
            addr = {addr[5:0], bits[nbits-i]};
        if (cmd) begin
            exp_q.push_back('{wr: 1'b0, addr: addr, data: 16'h0});
            data = model_regs[addr];
            for (int i = CLEN + 1; i <= FLEN && i <= nbits; i++)
                exp_miso[nbits-i] = data[FLEN-i];
        end else if (nbits >= FLEN) begin
            data = '0;
            for (int i = CLEN + 1; i <= FLEN; i++)
                data = {data[14:0], bits[nbits-i]};
            exp_q.push_back('{wr: 1'b1, addr: addr, data: data});
            model_regs[addr] = data;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] bits, input int nbits, input int rst_at, input int gap);
        logic [63:0] exp_miso;
        int          exp_err;
        int          err_base;
        modelFrame(bits, nbits, rst_at, exp_miso, exp_err);
        err_base = err_seen;
        miso_cap = '0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= nbits; i++) begin
            mosi = bits[nbits-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            miso_cap = {miso_cap[62:0], miso};
            if (i == CLEN + 2 && (rst_at == 0 || i < rst_at))
                checkOutput("busy_mid_frame", {busy, miso_oe}, 2'b11);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                checkOutput("reset_outputs",
                            {miso, miso_oe, reg_cs, reg_wr, reg_addr, reg_din, frame_err, busy}, 0);
                @(negedge clk);
                rst = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
        checkOutput("miso_stream", miso_cap, exp_miso);
        checkOutput("frame_err_count", err_seen - err_base, exp_err);
        checkOutput("missing_access", exp_q.size(), 0);
        checkOutput("busy_after_frame", {busy, miso_oe}, 2'b00);
        exp_q.delete();
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          base;
        logic [63:0] bits;
        int          nbits, kind, extra;
        logic        cmd;
        logic [6:0]  addr;
        logic [15:0] data;

        for (int i = 0; i < 128; i++)
            model_regs[i] = initVal(i);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_init",
                    {miso, miso_oe, reg_cs, reg_wr, reg_addr, reg_din, frame_err, busy}, 0);
        rst = 1'b0;
        bank_init = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] write 0x05 <- 0xA5C3");
        base = acc_count;
        applyStimulus(64'h05A5C3, 24, 0, GAP);
        checkOutput("t1_addr", reg_addr, 7'h05);
        checkOutput("t1_din", reg_din, 16'hA5C3);
        checkOutput("t1_bank", bank[5], 16'hA5C3);
        checkOutput("t1_accesses", acc_count - base, 1);

        $display("[TB] read 0x03");
        applyStimulus(64'h830000, 24, 0, GAP);
        checkOutput("t2_miso", miso_cap[23:0], 24'h001234);
        checkOutput("t2_addr", reg_addr, 7'h03);

        $display("[TB] truncated write");
        base = acc_count;
        applyStimulus(64'h06BEEF >> 4, 20, 0, GAP);
        checkOutput("t3_no_access", acc_count - base, 0);
        applyStimulus(64'h06BEEF, 24, 0, GAP);
        checkOutput("t3_recover_bank", bank[6], 16'hBEEF);

        $display("[TB] 30-bit write");
        base = acc_count;
        applyStimulus({40'h0, 24'h075A5A, 6'b101010} >> 6 << 6 | 64'b101010, 30, 0, GAP);
        checkOutput("t4_accesses", acc_count - base, 1);
        checkOutput("t4_din", reg_din, 16'h5A5A);

        $display("[TB] back-to-back write then read");
        base = acc_count;
        applyStimulus(64'h01FFFF, 24, 0, GAP);
        applyStimulus(64'h810000, 24, 0, GAP);
        checkOutput("t5_read_data", miso_cap[23:0], 24'h00FFFF);
        checkOutput("t5_accesses", acc_count - base, 2);

        $display("[TB] reset in the middle of a write");
        base = acc_count;
        applyStimulus(64'h081357, 24, 12, GAP);
        checkOutput("t6_no_access", acc_count - base, 0);
        checkOutput("t6_bank_kept", bank[8], initVal(8));
        applyStimulus(64'h082468, 24, 0, GAP);
        applyStimulus(64'h880000, 24, 0, GAP);
        checkOutput("t6_read_back", miso_cap[23:0], 24'h002468);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            cmd  = (kind == 9) ? 1'b1 : 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 7));
            data = 16'($urandom);
            bits = {40'h0, cmd, addr, data};
            nbits = FLEN;
            if (kind == 6) begin
                extra = $urandom_range(1, 8);
                bits  = (bits << extra) | 64'($urandom_range(0, 255) & ((1 << extra) - 1));
                nbits = FLEN + extra;
            end else if (kind == 7 || kind == 8) begin
                nbits = $urandom_range(0, FLEN - 1);
                bits  = bits >> (FLEN - nbits);
            end
            applyStimulus(bits, nbits, 0, GAP + $urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
